ahbl_splitter_dflt: RTL and testbench



---
 rtl/ahbl_splitter_dflt_pkg.sv | 18 +
 rtl/ahbl_splitter_dflt_if.sv | 53 +++++
 rtl/ahbl_splitter_dflt_default_slave.sv | 54 +++++
 rtl/ahbl_splitter_dflt.sv | 111 +++++++++++
 tb/tb_ahbl_splitter_dflt.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_splitter_dflt_pkg.sv
// Shared AHB-lite encodings for the splitter: HTRANS/HRESP codes and default-slave state encodings.
package ahbl_splitter_dflt_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahbl_splitter_dflt_if.sv
// Bus bundle for ahbl_splitter_dflt: one master-side AHB-lite port and N packed slave-side ports.
interface ahbl_splitter_dflt_if #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);

  logic                       ahblm_hready;
  logic                       ahblm_hready_resp;
  logic                       ahblm_hresp;
  logic [W_ADDR-1:0]          ahblm_haddr;
  logic                       ahblm_hwrite;
  logic [1:0]                 ahblm_htrans;
  logic [2:0]                 ahblm_hsize;
  logic [2:0]                 ahblm_hburst;
  logic [3:0]                 ahblm_hprot;
  logic                       ahblm_hmastlock;
  logic [W_DATA-1:0]          ahblm_hwdata;
  logic [W_DATA-1:0]          ahblm_hrdata;

  logic [N_PORTS-1:0]         ahbls_hready;
  logic [N_PORTS-1:0]         ahbls_hready_resp;
  logic [N_PORTS-1:0]         ahbls_hresp;
  logic [N_PORTS*W_ADDR-1:0]  ahbls_haddr;
  logic [N_PORTS-1:0]         ahbls_hwrite;
  logic [N_PORTS*2-1:0]       ahbls_htrans;
  logic [N_PORTS*3-1:0]       ahbls_hsize;
  logic [N_PORTS*3-1:0]       ahbls_hburst;
  logic [N_PORTS*4-1:0]       ahbls_hprot;
  logic [N_PORTS-1:0]         ahbls_hmastlock;
  logic [N_PORTS*W_DATA-1:0]  ahbls_hwdata;
  logic [N_PORTS*W_DATA-1:0]  ahbls_hrdata;

  // The splitter's view: slave to the upstream master, master to the downstream slaves.
  modport slave (
    input  ahblm_hready, ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
           ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
    output ahblm_hready_resp, ahblm_hresp, ahblm_hrdata,
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata
  );

  modport master (
    output ahblm_hready, ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
           ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
    input  ahblm_hready_resp, ahblm_hresp, ahblm_hrdata,
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata
  );

endinterface

// File: rtl/ahbl_splitter_dflt_default_slave.sv
// Internal default slave: answers active transfers to unmapped addresses with a two-cycle ERROR.
module ahbl_splitter_dflt_default_slave
  import ahbl_splitter_dflt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hready,
  input  logic req,
  output logic hready_resp,
  output logic hresp,
  output logic err_start
);

  ds_state_e state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DS_IDLE;
    else     state <= state_nxt;
  end

  // ERR1 stalls the bus itself, so it must advance regardless of hready.
  always_comb begin
    state_nxt   = state;
    hready_resp = 1'b1;
    hresp       = HRESP_OKAY;
    err_start   = 1'b0;
    case (state)
      DS_IDLE: begin
        if (hready && req) begin
          state_nxt = DS_ERR1;
          err_start = 1'b1;
        end
      end
      DS_ERR1: begin
        hready_resp = 1'b0;
        hresp       = HRESP_ERROR;
        state_nxt   = DS_ERR2;
      end
      DS_ERR2: begin
        hresp = HRESP_ERROR;
        if (hready) begin
          if (req) begin
            state_nxt = DS_ERR1;
            err_start = 1'b1;
          end else begin
            state_nxt = DS_IDLE;
          end
        end
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahbl_splitter_dflt.sv
// AHB-lite 1:N splitter with fixed-priority decode and a built-in default (ERROR) slave.
// Optional fault capture registers: define AHBL_SPLITTER_FAULT_CAPTURE_EN.
module ahbl_splitter_dflt
  import ahbl_splitter_dflt_pkg::*;
#(
  parameter int                        N_PORTS   = 2,
  parameter int                        W_ADDR    = 32,
  parameter int                        W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = 64'h20000000_00000000,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = 64'hf0000000_f0000000
) (
  input  logic                clk,
  input  logic                rst,
  ahbl_splitter_dflt_if.slave bus
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
  ,
  input  logic                fault_clr,
  output logic                fault_valid,
  output logic [W_ADDR-1:0]   fault_addr,
  output logic                fault_write
`endif
);

  logic [N_PORTS-1:0] hit;
  logic [N_PORTS-1:0] sel_a;
  logic [N_PORTS-1:0] sel_d;
  logic               unmapped;
  logic               ds_hready_resp;
  logic               ds_hresp;
  logic               err_start;
  logic [W_DATA-1:0]  mux_rdata;
  logic               mux_rdy;
  logic               mux_resp;

  // Address phase: decode, lowest-index hit wins.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      hit[i] = ((bus.ahblm_haddr ^ ADDR_MAP[i*W_ADDR +: W_ADDR])
                & ADDR_MASK[i*W_ADDR +: W_ADDR]) == '0;
    end
  end

  assign sel_a    = hit & (~hit + N_PORTS'(1));
  assign unmapped = ~|hit;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    assign bus.ahbls_htrans[i*2 +: 2] = sel_a[i] ? bus.ahblm_htrans : HTRANS_IDLE;
  end

  assign bus.ahbls_hready    = {N_PORTS{bus.ahblm_hready}};
  assign bus.ahbls_haddr     = {N_PORTS{bus.ahblm_haddr}};
  assign bus.ahbls_hwrite    = {N_PORTS{bus.ahblm_hwrite}};
  assign bus.ahbls_hsize     = {N_PORTS{bus.ahblm_hsize}};
  assign bus.ahbls_hburst    = {N_PORTS{bus.ahblm_hburst}};
  assign bus.ahbls_hprot     = {N_PORTS{bus.ahblm_hprot}};
  assign bus.ahbls_hmastlock = {N_PORTS{bus.ahblm_hmastlock}};
  assign bus.ahbls_hwdata    = {N_PORTS{bus.ahblm_hwdata}};

  // Data phase: remember which port owns the current data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   sel_d <= '0;
    else if (bus.ahblm_hready) sel_d <= sel_a;
  end

  ahbl_splitter_dflt_default_slave u_dflt (
    .clk         (clk),
    .rst         (rst),
    .hready      (bus.ahblm_hready),
    .req         (bus.ahblm_htrans[1] & unmapped),
    .hready_resp (ds_hready_resp),
    .hresp       (ds_hresp),
    .err_start   (err_start)
  );

  always_comb begin
    mux_rdata = '0;
    mux_rdy   = 1'b0;
    mux_resp  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      mux_rdata = mux_rdata | ({W_DATA{sel_d[i]}} & bus.ahbls_hrdata[i*W_DATA +: W_DATA]);
      mux_rdy   = mux_rdy  | (sel_d[i] & bus.ahbls_hready_resp[i]);
      mux_resp  = mux_resp | (sel_d[i] & bus.ahbls_hresp[i]);
    end
  end

  assign bus.ahblm_hrdata      = mux_rdata;
  assign bus.ahblm_hready_resp = (|sel_d) ? mux_rdy  : ds_hready_resp;
  assign bus.ahblm_hresp       = (|sel_d) ? mux_resp : ds_hresp;

`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
  // First fault is kept until software clears it; a new capture beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_write <= 1'b0;
    end else if (err_start && !fault_valid) begin
      fault_valid <= 1'b1;
      fault_addr  <= bus.ahblm_haddr;
      fault_write <= bus.ahblm_hwrite;
    end else if (fault_clr) begin
      fault_valid <= 1'b0;
    end
  end
`else
  logic unused_err_start;
  assign unused_err_start = err_start;
`endif

endmodule

// File: tb/tb_ahbl_splitter_dflt.sv
// Bench for ahbl_splitter_dflt: directed AHB-lite traffic, per-cycle model comparison plus literal checks.
module tb_ahbl_splitter_dflt;
  import ahbl_splitter_dflt_pkg::*;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  ahbl_splitter_dflt_if #(.N_PORTS(NP), .W_ADDR(AW), .W_DATA(DW)) bus ();
  ahbl_splitter_dflt_if #(.N_PORTS(NP), .W_ADDR(AW), .W_DATA(DW)) bus2 ();

`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
  logic          fault_clr;
  logic          fault_valid;
  logic [AW-1:0] fault_addr;
  logic          fault_write;
  logic          unused_f2_valid;
  logic [AW-1:0] unused_f2_addr;
  logic          unused_f2_write;
`endif

  ahbl_splitter_dflt #(
    .N_PORTS(NP), .W_ADDR(AW), .W_DATA(DW),
    .ADDR_MAP(64'h20000000_00000000), .ADDR_MASK(64'hf0000000_f0000000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
    ,
    .fault_clr(fault_clr),
    .fault_valid(fault_valid),
    .fault_addr(fault_addr),
    .fault_write(fault_write)
`endif
  );

  // Second instance with both ports mapped at 0x0 to exercise overlap priority.
  ahbl_splitter_dflt #(
    .N_PORTS(NP), .W_ADDR(AW), .W_DATA(DW),
    .ADDR_MAP(64'h00000000_00000000), .ADDR_MASK(64'hf0000000_f0000000)
  ) dut_ovl (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
    ,
    .fault_clr(fault_clr),
    .fault_valid(unused_f2_valid),
    .fault_addr(unused_f2_addr),
    .fault_write(unused_f2_write)
`endif
  );

  // Top of fabric: bus-wide HREADY is the splitter's own data-phase ready.
  assign bus.ahblm_hready       = bus.ahblm_hready_resp;
  assign bus2.ahblm_hready      = bus2.ahblm_hready_resp;
  assign bus2.ahblm_haddr       = bus.ahblm_haddr;
  assign bus2.ahblm_hwrite      = bus.ahblm_hwrite;
  assign bus2.ahblm_htrans      = bus.ahblm_htrans;
  assign bus2.ahblm_hsize       = bus.ahblm_hsize;
  assign bus2.ahblm_hburst      = bus.ahblm_hburst;
  assign bus2.ahblm_hprot       = bus.ahblm_hprot;
  assign bus2.ahblm_hmastlock   = bus.ahblm_hmastlock;
  assign bus2.ahblm_hwdata      = bus.ahblm_hwdata;
  assign bus2.ahbls_hready_resp = bus.ahbls_hready_resp;
  assign bus2.ahbls_hresp       = bus.ahbls_hresp;
  assign bus2.ahbls_hrdata      = bus.ahbls_hrdata;

  logic unused_dut2;
  assign unused_dut2 = ^{bus2.ahblm_hrdata, bus2.ahblm_hresp, bus2.ahbls_haddr,
                         bus2.ahbls_hwrite, bus2.ahbls_hsize, bus2.ahbls_hburst,
                         bus2.ahbls_hprot, bus2.ahbls_hmastlock, bus2.ahbls_hwdata,
                         bus2.ahbls_hready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Address map as ranges: port0 owns [0x0,0x1000_0000), port1 owns [0x2000_0000,0x3000_0000).
  function automatic int decode(input logic [31:0] a, input bit ovl);
    if (a < 32'h1000_0000) return 0;
    if (!ovl && a >= 32'h2000_0000 && a < 32'h3000_0000) return 1;
    return -1;
  endfunction

  task automatic addr_ph(input logic [31:0] a, input logic [1:0] t, input logic w);
    bus.ahblm_haddr     = a;
    bus.ahblm_htrans    = t;
    bus.ahblm_hwrite    = w;
    bus.ahblm_hsize     = 3'd2;
    bus.ahblm_hburst    = {1'b0, t};
    bus.ahblm_hprot     = a[3:0] ^ 4'h3;
    bus.ahblm_hmastlock = w;
    bus.ahblm_hwdata    = ~a;
  endtask

  task automatic slv(input logic [1:0] rdy, input logic [1:0] rsp,
                     input logic [31:0] d0, input logic [31:0] d1);
    bus.ahbls_hready_resp = rdy;
    bus.ahbls_hresp       = rsp;
    bus.ahbls_hrdata      = {d1, d0};
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: owner of the current data phase (-1 = default slave) and cycles of ERROR left (2, 1, 0).
  int            owner;
  int            err_left;
  bit            m_fv;
  logic [31:0]   m_fa;
  bit            m_fw;

  initial begin : compare
    int          dec;
    int          dec2;
    bit          active;
    bit          start;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    owner = -1; err_left = 0; m_fv = 0; m_fa = '0; m_fw = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        owner = -1; err_left = 0; m_fv = 0; m_fa = '0; m_fw = 0;
        chk("m_rst_rdy", bus.ahblm_hready_resp, 1);
        chk("m_rst_resp", bus.ahblm_hresp, 0);
        chk("m_rst_rdata", bus.ahblm_hrdata, 0);
        continue;
      end
      dec  = decode(bus.ahblm_haddr, 1'b0);
      dec2 = decode(bus.ahblm_haddr, 1'b1);
      if (owner >= 0) begin
        e_rdy  = bus.ahbls_hready_resp[owner];
        e_resp = bus.ahbls_hresp[owner];
        e_data = bus.ahbls_hrdata[owner*32 +: 32];
      end else begin
        e_rdy  = (err_left != 2);
        e_resp = (err_left != 0);
        e_data = '0;
      end
      chk("m_hready_resp", bus.ahblm_hready_resp, e_rdy);
      chk("m_hresp", bus.ahblm_hresp, e_resp);
      chk("m_hrdata", bus.ahblm_hrdata, e_data);
      for (int i = 0; i < NP; i++) begin
        chk("m_htrans", bus.ahbls_htrans[i*2 +: 2], (i == dec) ? bus.ahblm_htrans : 2'b00);
        chk("m_ovl_htrans", bus2.ahbls_htrans[i*2 +: 2], (i == dec2) ? bus.ahblm_htrans : 2'b00);
        chk("m_bcast",
            {bus.ahbls_haddr[i*32 +: 32], bus.ahbls_hwrite[i], bus.ahbls_hsize[i*3 +: 3],
             bus.ahbls_hburst[i*3 +: 3], bus.ahbls_hprot[i*4 +: 4], bus.ahbls_hmastlock[i],
             bus.ahbls_hready[i]},
            {bus.ahblm_haddr, bus.ahblm_hwrite, bus.ahblm_hsize, bus.ahblm_hburst,
             bus.ahblm_hprot, bus.ahblm_hmastlock, e_rdy});
        chk("m_hwdata", bus.ahbls_hwdata[i*32 +: 32], bus.ahblm_hwdata);
      end
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
      chk("m_fault_valid", fault_valid, m_fv);
      chk("m_fault_addr", fault_addr, m_fa);
      chk("m_fault_write", fault_write, m_fw);
`endif
      active = bus.ahblm_htrans[1];
      start  = (err_left != 2) && e_rdy && active && (dec < 0);
      if (start && !m_fv) begin
        m_fv = 1; m_fa = bus.ahblm_haddr; m_fw = bus.ahblm_hwrite;
      end
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
      else if (fault_clr) m_fv = 0;
`endif
      if (err_left == 2) begin
        err_left = 1;
      end else if (e_rdy) begin
        owner    = dec;
        err_left = start ? 2 : 0;
      end
    end
  end

  initial begin : stim
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    addr_ph(32'h0, HTRANS_IDLE, 1'b0);
    slv(2'b11, 2'b00, 32'h0, 32'h0);
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
    fault_clr = 1'b0;
`endif
    @(negedge clk);
    chk("rst_hready_resp", bus.ahblm_hready_resp, 1);
    chk("rst_hresp", bus.ahblm_hresp, 0);
    chk("rst_hrdata", bus.ahblm_hrdata, 0);
    next_cyc();
    rst = 1'b0;

    // Read 0x2000_0010 decodes to port1; slave adds one wait state.
    addr_ph(32'h2000_0010, HTRANS_NONSEQ, 1'b0);
    @(negedge clk);
    chk("rd_htrans1", bus.ahbls_htrans[3:2], 2'b10);
    chk("rd_htrans0", bus.ahbls_htrans[1:0], 2'b00);
    chk("ovl_unmapped_htrans", bus2.ahbls_htrans, 4'b0000);
    next_cyc();
    addr_ph(32'h4000_0000, HTRANS_NONSEQ, 1'b1);
    slv(2'b01, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("rd_wait_rdy", bus.ahblm_hready_resp, 0);
    chk("rd_wait_resp", bus.ahblm_hresp, 0);
    next_cyc();
    addr_ph(32'h0, HTRANS_IDLE, 1'b0);
    slv(2'b11, 2'b00, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_done_rdy", bus.ahblm_hready_resp, 1);
    chk("rd_done_data", bus.ahblm_hrdata, 32'hDEADBEEF);
    chk("rd_done_resp", bus.ahblm_hresp, 0);
    next_cyc();

    // Single unmapped NONSEQ.
    addr_ph(32'h4000_0000, HTRANS_NONSEQ, 1'b1);
    slv(2'b11, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("um_no_htrans", bus.ahbls_htrans, 4'b0000);
    chk("um_prev_okay", bus.ahblm_hresp, 0);
    next_cyc();
    addr_ph(32'h4000_0000, HTRANS_IDLE, 1'b0);
    @(negedge clk);
    chk("um_err1_rdy", bus.ahblm_hready_resp, 0);
    chk("um_err1_resp", bus.ahblm_hresp, 1);
    next_cyc();
    @(negedge clk);
    chk("um_err2_rdy", bus.ahblm_hready_resp, 1);
    chk("um_err2_resp", bus.ahblm_hresp, 1);
    next_cyc();

    // Back-to-back unmapped NONSEQs.
    addr_ph(32'h4000_0000, HTRANS_NONSEQ, 1'b0);
    @(negedge clk);
    chk("idle_um_okay_rdy", bus.ahblm_hready_resp, 1);
    chk("idle_um_okay_resp", bus.ahblm_hresp, 0);
    next_cyc();
    addr_ph(32'h4000_0000, HTRANS_IDLE, 1'b0);
    @(negedge clk);
    chk("b2b_err1a", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b01);
    next_cyc();
    addr_ph(32'h4000_0100, HTRANS_NONSEQ, 1'b0);
    @(negedge clk);
    chk("b2b_err2a", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b11);
    next_cyc();
    addr_ph(32'h4000_0100, HTRANS_IDLE, 1'b0);
    @(negedge clk);
    chk("b2b_err1b", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b01);
    next_cyc();
    @(negedge clk);
    chk("b2b_err2b", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b11);
    next_cyc();

    // Read port0, then unmapped write that is captured as a fault.
    addr_ph(32'h0000_0040, HTRANS_NONSEQ, 1'b0);
    @(negedge clk);
    chk("b2b_okay", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b10);
    chk("ovl_port0_htrans", bus2.ahbls_htrans[1:0], 2'b10);
    chk("ovl_port1_htrans", bus2.ahbls_htrans[3:2], 2'b00);
    next_cyc();
    addr_ph(32'h4000_0004, HTRANS_NONSEQ, 1'b1);
    slv(2'b11, 2'b00, 32'h12345678, 32'h0);
    @(negedge clk);
    chk("rd0_data", bus.ahblm_hrdata, 32'h12345678);
    next_cyc();
    addr_ph(32'h4000_0004, HTRANS_IDLE, 1'b0);
    @(negedge clk);
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
    chk("fc_valid", fault_valid, 1);
    chk("fc_addr", fault_addr, 32'h4000_0004);
    chk("fc_write", fault_write, 1);
`endif
    next_cyc();
    addr_ph(32'h4000_0008, HTRANS_NONSEQ, 1'b0);
    @(negedge clk);
    next_cyc();
    addr_ph(32'h4000_0008, HTRANS_IDLE, 1'b0);
    @(negedge clk);
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
    chk("fc_keep_addr", fault_addr, 32'h4000_0004);
    chk("fc_keep_write", fault_write, 1);
`endif
    next_cyc();
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
    fault_clr = 1'b1;
`endif
    @(negedge clk);
    next_cyc();
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
    fault_clr = 1'b0;
`endif

    // Asynchronous reset in the middle of ERR1.
    addr_ph(32'h6000_0000, HTRANS_NONSEQ, 1'b0);
    @(negedge clk);
`ifdef AHBL_SPLITTER_FAULT_CAPTURE_EN
    chk("fc_cleared", fault_valid, 0);
`endif
    next_cyc();
    addr_ph(32'h6000_0000, HTRANS_IDLE, 1'b0);
    @(negedge clk);
    chk("pre_rst_err1", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rdy", bus.ahblm_hready_resp, 1);
    chk("async_rst_resp", bus.ahblm_hresp, 0);
    next_cyc();
    @(negedge clk);
    chk("in_rst_okay", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b10);
    next_cyc();
    rst = 1'b0;

    // SEQ/BUSY routing, then a slave ERROR passed through.
    addr_ph(32'h2000_0004, HTRANS_SEQ, 1'b1);
    @(negedge clk);
    chk("seq_htrans1", bus.ahbls_htrans[3:2], 2'b11);
    next_cyc();
    addr_ph(32'h7000_0000, HTRANS_BUSY, 1'b0);
    @(negedge clk);
    chk("busy_um_htrans", bus.ahbls_htrans, 4'b0000);
    next_cyc();
    addr_ph(32'h0000_0008, HTRANS_NONSEQ, 1'b0);
    @(negedge clk);
    chk("busy_um_okay", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b10);
    next_cyc();
    addr_ph(32'h0, HTRANS_IDLE, 1'b0);
    slv(2'b10, 2'b01, 32'h0, 32'h0);
    @(negedge clk);
    chk("s0_err1", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b01);
    next_cyc();
    slv(2'b11, 2'b01, 32'h0, 32'h0);
    @(negedge clk);
    chk("s0_err2", {bus.ahblm_hready_resp, bus.ahblm_hresp}, 2'b11);
    next_cyc();
    slv(2'b11, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
